// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared types and helpers for the word-scramble game round timer.
//   - Mode encoding for the lettNum select (3, 4 or 5 letter rounds)
//   - Timer state enumeration used by game_timer
//   - BCD digit and digit-pair types for the seven-segment path
//   - secToBcd(): converts a binary seconds value 0..99 into a BCD pair
// ---------------------------------------------------------------------------
package game_pkg;

    // Mode encoding driven by the game controller on lettNum.
    // Encoding 3 is not a distinct mode; it shares the 5-letter duration.
    localparam logic [1:0] MODE_3L = 2'd0;
    localparam logic [1:0] MODE_4L = 2'd1;
    localparam logic [1:0] MODE_5L = 2'd2;

    // Round timer states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOADED  = 3'd1,
        RUN     = 3'd2,
        PAUSE   = 3'd3,
        EXPIRED = 3'd4
    } timerState_t;

    // One BCD digit (0..9 in a 4-bit field).
    typedef logic [3:0] bcdDigit_t;

    // Two-digit seconds value as shown on the display.
    typedef struct packed {
        bcdDigit_t tens;
        bcdDigit_t ones;
    } bcdPair_t;

    // Binary seconds (0..99) to BCD tens/ones. Only ever called with
    // elaboration-time constants, so the divide folds away in synthesis.
    function automatic bcdPair_t secToBcd(input int sec);
        bcdPair_t result;
        result.tens = bcdDigit_t'((sec / 10) % 10);
        result.ones = bcdDigit_t'(sec % 10);
        return result;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Divides the system clock down to a one-second tick for the round timer.
// The count advances only while en is high and is held otherwise, so a
// paused round resumes part-way through the current second.
//
// Parameters:
//   TICK_DIV  clk cycles per tick (>= 2)
// Ports:
//   clk   input   system clock
//   rst   input   asynchronous active-high reset, clears the count
//   en    input   advance the count this cycle
//   clr   input   synchronous clear; overrides en
//   tick  output  high for the one cycle in which the count is at its
//                 last value while enabled; the count wraps on that edge
// ---------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    // Cycle counter. A clear wins over counting so a reconfig always starts
    // the next round on a fresh second. When disabled the value is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    // The tick is decoded from the registered count so the parent can act on
    // it in the same cycle the count wraps.
    assign tick = en && !clr && (count == LAST);

endmodule

// File: rtl/game_timer.sv
// ---------------------------------------------------------------------------
// game_timer
// Countdown round timer for the word-scramble game. The game controller
// preloads a per-mode duration with timerReconfig (mode on lettNum), then
// holds timerEn high during play. The remaining seconds are kept directly in
// BCD so they can feed the seven-segment path with no conversion.
//
// Optional feature (macro GAME_TIMER_BONUS_EN):
//   Adds input bonusPls. Each pulse during RUN or PAUSE adds BONUS_SEC seconds
//   to the count (BCD add, saturating at 99). Without the macro the port and
//   the add logic are absent.
//
// Parameters:
//   TICK_DIV   clk cycles per one-second tick (>= 2)
//   TIME_M0    round length for lettNum=0 (1..99)
//   TIME_M1    round length for lettNum=1 (1..99)
//   TIME_M2    round length for lettNum=2 and 3 (1..99)
//   BONUS_SEC  seconds added per bonus pulse (1..9)
// Ports:
//   clk            input   system clock
//   rst            input   asynchronous active-high reset
//   timerReconfig  input   load duration for lettNum, aborts any run
//   timerEn        input   count while high, pause while low
//   lettNum[1:0]   input   mode select, sampled on the reconfig cycle only
//   bonusPls       input   bonus pulse (GAME_TIMER_BONUS_EN builds only)
//   timeOut        output  high once the count reaches 00, held until reload
//   running        output  high while counting (RUN state)
//   secOnes[3:0]   output  BCD ones digit of seconds remaining
//   secTens[3:0]   output  BCD tens digit of seconds remaining
// ---------------------------------------------------------------------------
module game_timer
    import game_pkg::*;
#(
    parameter int TICK_DIV  = 50000000,
    parameter int TIME_M0   = 60,
    parameter int TIME_M1   = 45,
    parameter int TIME_M2   = 30,
    parameter int BONUS_SEC = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       timerReconfig,
    input  logic       timerEn,
    input  logic [1:0] lettNum,
`ifdef GAME_TIMER_BONUS_EN
    input  logic       bonusPls,
`endif
    output logic       timeOut,
    output logic       running,
    output logic [3:0] secOnes,
    output logic [3:0] secTens
);

    timerState_t state;

    logic     tick;
    logic     prescalerEn;
    bcdPair_t loadBcd;
    bcdPair_t baseBcd;
    bcdPair_t decBcd;
    logic     decIsZero;

    // Durations of zero (or beyond two digits) would make the round expire
    // before it starts or overflow the display, so flag them loudly in
    // simulation. The check sits on the clock so it fires once the design
    // is actually running.
    always_ff @(posedge clk) begin
        assert (TIME_M0 >= 1 && TIME_M0 <= 99 &&
                TIME_M1 >= 1 && TIME_M1 <= 99 &&
                TIME_M2 >= 1 && TIME_M2 <= 99 &&
                TICK_DIV >= 2 &&
                BONUS_SEC >= 1 && BONUS_SEC <= 9);
    end

    // The prescaler only advances while actively counting. A reconfig clears
    // it, and also masks counting in that cycle so a stale RUN state cannot
    // produce a tick alongside the reload.
    assign prescalerEn = (state == RUN) && timerEn && !timerReconfig;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (prescalerEn),
        .clr (timerReconfig),
        .tick(tick)
    );

    // Mode to duration lookup. Encoding 3 shares the 5-letter duration.
    always_comb begin
        loadBcd = secToBcd(TIME_M2);
        case (lettNum)
            MODE_3L: loadBcd = secToBcd(TIME_M0);
            MODE_4L: loadBcd = secToBcd(TIME_M1);
            MODE_5L: loadBcd = secToBcd(TIME_M2);
            default: loadBcd = secToBcd(TIME_M2);
        endcase
    end

`ifdef GAME_TIMER_BONUS_EN
    logic       bonusApply;
    logic [4:0] onesSum;
    logic [4:0] tensSum;
    logic       onesCarry;

    assign bonusApply = bonusPls && ((state == RUN) || (state == PAUSE));

    // Digit-wise BCD add of the bonus: add into the ones digit, correct
    // anything past 9 with a carry into tens, and clamp to 99 when the tens
    // digit would overflow. The result feeds the decrement below so a bonus
    // landing on the final tick rescues the round instead of expiring it.
    always_comb begin
        onesSum   = {1'b0, secOnes} + 5'(BONUS_SEC);
        onesCarry = 1'b0;
        tensSum   = {1'b0, secTens};
        baseBcd   = '{tens: secTens, ones: secOnes};
        if (bonusApply) begin
            if (onesSum > 5'd9) begin
                onesSum   = onesSum - 5'd10;
                onesCarry = 1'b1;
            end
            tensSum = {1'b0, secTens} + {4'd0, onesCarry};
            if (tensSum > 5'd9) begin
                baseBcd = '{tens: 4'd9, ones: 4'd9};
            end else begin
                baseBcd = '{tens: tensSum[3:0], ones: onesSum[3:0]};
            end
        end
    end
`else
    // Without bonus support the decrement works straight from the digits.
    assign baseBcd = '{tens: secTens, ones: secOnes};
`endif

    // One-second BCD decrement: ones borrow from tens when they hit zero.
    // Never used when the count is already 00 since that state is EXPIRED.
    always_comb begin
        decBcd = baseBcd;
        if (baseBcd.ones == 4'd0) begin
            decBcd.ones = 4'd9;
            decBcd.tens = baseBcd.tens - 4'd1;
        end else begin
            decBcd.ones = baseBcd.ones - 4'd1;
        end
    end

    assign decIsZero = (decBcd.tens == 4'd0) && (decBcd.ones == 4'd0);

    // Main timer state machine with registered outputs. Reconfig is checked
    // first so it aborts whatever the timer was doing; the enable seen in
    // that same cycle is deliberately ignored. In RUN the digits always take
    // the (possibly bonus-adjusted) value, then the decrement if a tick lands.
    // Reaching 00 raises timeOut and drops running on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            secTens <= 4'd0;
            secOnes <= 4'd0;
            timeOut <= 1'b0;
            running <= 1'b0;
        end else if (timerReconfig) begin
            state   <= LOADED;
            secTens <= loadBcd.tens;
            secOnes <= loadBcd.ones;
            timeOut <= 1'b0;
            running <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    running <= 1'b0;
                end
                LOADED: begin
                    if (timerEn) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    secTens <= baseBcd.tens;
                    secOnes <= baseBcd.ones;
                    if (!timerEn) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end else if (tick) begin
                        secTens <= decBcd.tens;
                        secOnes <= decBcd.ones;
                        if (decIsZero) begin
                            state   <= EXPIRED;
                            timeOut <= 1'b1;
                            running <= 1'b0;
                        end
                    end
                end
                PAUSE: begin
                    secTens <= baseBcd.tens;
                    secOnes <= baseBcd.ones;
                    if (timerEn) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                EXPIRED: begin
                    timeOut <= 1'b1;
                    running <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_timer.sv
// ---------------------------------------------------------------------------
// tb_game_timer
// Directed self-checking bench for game_timer with a 4-cycle tick and short
// durations (M0=3, M1=10, M2=30). Bonus steps compile in only when
// GAME_TIMER_BONUS_EN is defined.
// ---------------------------------------------------------------------------
module tb_game_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       timerReconfig = 1'b0;
    logic       timerEn = 1'b0;
    logic [1:0] lettNum = 2'd0;
`ifdef GAME_TIMER_BONUS_EN
    logic       bonusPls = 1'b0;
`endif
    logic       timeOut;
    logic       running;
    logic [3:0] secOnes;
    logic [3:0] secTens;

    int nCompared = 0;
    int nMismatched = 0;

    game_timer #(
        .TICK_DIV (4),
        .TIME_M0  (3),
        .TIME_M1  (10),
        .TIME_M2  (30),
        .BONUS_SEC(5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .timerReconfig(timerReconfig),
        .timerEn      (timerEn),
        .lettNum      (lettNum),
`ifdef GAME_TIMER_BONUS_EN
        .bonusPls     (bonusPls),
`endif
        .timeOut      (timeOut),
        .running      (running),
        .secOnes      (secOnes),
        .secTens      (secTens)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 unit past the last one.
    task automatic stepClk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic reconfig, input logic en,
                                 input logic [1:0] lett);
        timerReconfig = reconfig;
        timerEn       = en;
        lettNum       = lett;
    endtask

`ifdef GAME_TIMER_BONUS_EN
    task automatic setBonus(input logic pls);
        bonusPls = pls;
    endtask
`endif

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkState(input string tag, input logic [7:0] expDigits,
                              input logic expTimeOut, input logic expRunning);
        checkOutput({tag, " digits"},  {secTens, secOnes}, expDigits);
        checkOutput({tag, " timeOut"}, {7'd0, timeOut},    {7'd0, expTimeOut});
        checkOutput({tag, " running"}, {7'd0, running},    {7'd0, expRunning});
    endtask

    initial begin
        $display("[TB] game_timer directed bench start");

        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        checkState("reset", 8'h00, 1'b0, 1'b0);
        stepClk(2);
        rst = 1'b0;

        // IDLE ignores timerEn
        applyStimulus(1'b0, 1'b1, 2'd0);
        stepClk(3);
        checkState("idle ignores en", 8'h00, 1'b0, 1'b0);

        // Mode 0: 03 -> 02 -> 01 -> 00 at 4-cycle intervals
        applyStimulus(1'b1, 1'b0, 2'd0);
        stepClk(1);
        checkState("load m0", 8'h03, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd0);
        stepClk(1);
        checkState("m0 run entry", 8'h03, 1'b0, 1'b1);
        stepClk(3);
        checkState("m0 before 1st tick", 8'h03, 1'b0, 1'b1);
        stepClk(1);
        checkState("m0 tick1", 8'h02, 1'b0, 1'b1);
        stepClk(4);
        checkState("m0 tick2", 8'h01, 1'b0, 1'b1);
        stepClk(3);
        checkState("m0 before expiry", 8'h01, 1'b0, 1'b1);
        stepClk(1);
        checkState("m0 expiry", 8'h00, 1'b1, 1'b0);
        stepClk(20);
        checkState("m0 expired hold", 8'h00, 1'b1, 1'b0);

        // Reconfig from EXPIRED with lettNum=3, timerEn high is ignored
        applyStimulus(1'b1, 1'b1, 2'd3);
        stepClk(1);
        checkState("reload m3", 8'h30, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 2'd0);
        stepClk(6);
        checkState("loaded waits", 8'h30, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd0);
        stepClk(1);
        checkState("m3 run entry", 8'h30, 1'b0, 1'b1);
        stepClk(2);

        // Reconfig mid-run to mode 1, then 10 -> 09 -> 08
        applyStimulus(1'b1, 1'b1, 2'd1);
        stepClk(1);
        checkState("reload mid-run", 8'h10, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd0);
        stepClk(1);
        checkState("m1 run entry", 8'h10, 1'b0, 1'b1);
        stepClk(3);
        checkState("m1 before tick", 8'h10, 1'b0, 1'b1);
        stepClk(1);
        checkState("m1 borrow", 8'h09, 1'b0, 1'b1);
        stepClk(4);
        checkState("m1 tick2", 8'h08, 1'b0, 1'b1);

        // Pause after 2 cycles, hold low 10 cycles, resume
        stepClk(2);
        applyStimulus(1'b0, 1'b0, 2'd0);
        stepClk(1);
        checkState("pause entry", 8'h08, 1'b0, 1'b0);
        stepClk(9);
        checkState("pause hold", 8'h08, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd0);
        stepClk(1);
        checkState("resume", 8'h08, 1'b0, 1'b1);
        stepClk(1);
        checkState("resume +1", 8'h08, 1'b0, 1'b1);
        stepClk(1);
        checkState("resume tick", 8'h07, 1'b0, 1'b1);

        // Async reset asserted between clock edges mid-RUN
        stepClk(1);
        #3 rst = 1'b1;
        #1;
        checkState("async reset", 8'h00, 1'b0, 1'b0);
        stepClk(1);
        rst = 1'b0;
        stepClk(3);
        checkState("post reset idle", 8'h00, 1'b0, 1'b0);

`ifdef GAME_TIMER_BONUS_EN
        // Bonus ignored in LOADED
        applyStimulus(1'b1, 1'b0, 2'd1);
        stepClk(1);
        applyStimulus(1'b0, 1'b0, 2'd0);
        setBonus(1'b1);
        stepClk(1);
        setBonus(1'b0);
        checkState("bonus in loaded", 8'h10, 1'b0, 1'b0);

        // 08 + 5 -> 13 while paused
        applyStimulus(1'b0, 1'b1, 2'd0);
        stepClk(1);
        stepClk(8);
        checkState("bonus pre 08", 8'h08, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 2'd0);
        stepClk(1);
        setBonus(1'b1);
        stepClk(1);
        setBonus(1'b0);
        checkState("bonus 08->13", 8'h13, 1'b0, 1'b0);

        // Bonus coinciding with the tick at 01 -> 05, no expiry
        applyStimulus(1'b1, 1'b0, 2'd0);
        stepClk(1);
        applyStimulus(1'b0, 1'b1, 2'd0);
        stepClk(1);
        stepClk(8);
        checkState("bonus pre 01", 8'h01, 1'b0, 1'b1);
        stepClk(3);
        setBonus(1'b1);
        stepClk(1);
        setBonus(1'b0);
        checkState("bonus on last tick", 8'h05, 1'b0, 1'b1);

        // Run down to 02, pause, pulse up to 97 then saturate at 99
        stepClk(12);
        checkState("bonus pre 02", 8'h02, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 2'd0);
        stepClk(1);
        setBonus(1'b1);
        stepClk(19);
        setBonus(1'b0);
        checkState("bonus to 97", 8'h97, 1'b0, 1'b0);
        setBonus(1'b1);
        stepClk(1);
        checkState("bonus 97->99", 8'h99, 1'b0, 1'b0);
        stepClk(1);
        setBonus(1'b0);
        checkState("bonus 99 sat", 8'h99, 1'b0, 1'b0);

        // Resume from 99 with prescaler at 0: next tick after 4 cycles
        applyStimulus(1'b0, 1'b1, 2'd0);
        stepClk(1);
        stepClk(4);
        checkState("bonus 99->98", 8'h98, 1'b0, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
